// File: rtl/bcd_ctrl_pkg.sv
// State encoding, BCD limit constant and step clamping used by the BCD count controller.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SAT   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // A zero step would stall the count, and anything above 9 is not a BCD digit.
    function automatic logic [3:0] clamp_step(input logic [3:0] step);
        if (step == 4'd0) return 4'd1;
        if (step > BCD_MAX) return BCD_MAX;
        return step;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides i_Clk into count ticks. Holds its value when not running, so a resume continues mid-period.
module tick_prescaler #(
    parameter logic [7:0] P_DIV = 8'd10
) (
    input  logic i_Clk,
    input  logic i_GRst,
    input  logic i_Run,
    input  logic i_Zero,
    output logic o_Term
);

    logic [7:0] cnt_q;

    assign o_Term = i_Run && (cnt_q == P_DIV - 8'd1);

    always_ff @(posedge i_Clk or posedge i_GRst) begin
        if (i_GRst) begin
            cnt_q <= 8'd0;
        end else if (i_Zero || o_Term) begin
            cnt_q <= 8'd0;
        end else if (i_Run) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear controller for a two-digit BCD count with prescaled ticks and saturation.
// state | meaning
// IDLE  | cleared, waiting for start
// RUN   | prescaler running, digits advance on each terminal count
// PAUSE | halted mid-period, prescaler held
// SAT   | limit reached, held until clear or reset
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter logic [7:0] P_DIV     = 8'd10,
    parameter logic [3:0] P_LIMIT_T = 4'd9,
    parameter logic [3:0] P_LIMIT_U = 4'd9
) (
    input  logic       i_Clk,
    input  logic       i_GRst,
    input  logic       i_Start,
    input  logic       i_Stop,
    input  logic       i_Clear,
    input  logic [3:0] i_Step,
    output logic [3:0] o_QU,
    output logic [3:0] o_QT,
    output logic       o_Tick,
    output logic       o_Carry,
    output logic       o_Sat,
    output logic [1:0] o_State
);

    state_t     state_q, state_d;
    logic [3:0] qu_d, qt_d, step_eff, units_raw;
    logic [4:0] sum, tens_raw;
    logic       tick_d, carry_d, wrap, hit_limit, run_en, pre_zero, term;

    assign step_eff  = clamp_step(i_Step);
    assign sum       = {1'b0, o_QU} + {1'b0, step_eff};
    assign wrap      = (sum >= 5'd10);
    assign units_raw = wrap ? 4'(sum - 5'd10) : sum[3:0];
    assign tens_raw  = {1'b0, o_QT} + {4'd0, wrap};

    // Comparing tens first then units equals 10*T+U >= L since units stay BCD; tens of 10 always hits.
    assign hit_limit = (tens_raw > {1'b0, P_LIMIT_T}) ||
                       ((tens_raw == {1'b0, P_LIMIT_T}) && (units_raw >= P_LIMIT_U));

    assign run_en   = (state_q == ST_RUN) && !i_Clear && !i_Stop;
    assign pre_zero = i_Clear || ((state_q == ST_IDLE) && i_Start && !i_Stop);

    tick_prescaler #(
        .P_DIV (P_DIV)
    ) u_prescaler (
        .i_Clk  (i_Clk),
        .i_GRst (i_GRst),
        .i_Run  (run_en),
        .i_Zero (pre_zero),
        .o_Term (term)
    );

    always_comb begin
        state_d = state_q;
        qu_d    = o_QU;
        qt_d    = o_QT;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (i_Clear) begin
            state_d = ST_IDLE;
            qu_d    = 4'd0;
            qt_d    = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Start && !i_Stop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (i_Stop) begin
                        state_d = ST_PAUSE;
                    end else if (term) begin
                        tick_d  = 1'b1;
                        carry_d = wrap;
                        if (hit_limit) begin
                            qu_d    = P_LIMIT_U;
                            qt_d    = P_LIMIT_T;
                            state_d = ST_SAT;
                        end else begin
                            qu_d = units_raw;
                            qt_d = tens_raw[3:0];
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_Start && !i_Stop) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_SAT;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_GRst) begin
        if (i_GRst) begin
            state_q <= ST_IDLE;
            o_QU    <= 4'd0;
            o_QT    <= 4'd0;
            o_Tick  <= 1'b0;
            o_Carry <= 1'b0;
        end else begin
            state_q <= state_d;
            o_QU    <= qu_d;
            o_QT    <= qt_d;
            o_Tick  <= tick_d;
            o_Carry <= carry_d;
        end
    end

    assign o_Sat   = (state_q == ST_SAT);
    assign o_State = state_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: three parameterisations share one stimulus stream and are each tracked by a value-level model.
module tb_bcd_count_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, clear;
    logic [3:0] step;

    logic [3:0] qu_a, qt_a, qu_b, qt_b, qu_c, qt_c;
    logic       tick_a, carry_a, sat_a, tick_b, carry_b, sat_b, tick_c, carry_c, sat_c;
    logic [1:0] state_a, state_b, state_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_count_ctrl #(.P_DIV(8'd4), .P_LIMIT_T(4'd9), .P_LIMIT_U(4'd9)) dut_a (
        .i_Clk(clk), .i_GRst(rst), .i_Start(start), .i_Stop(stop), .i_Clear(clear), .i_Step(step),
        .o_QU(qu_a), .o_QT(qt_a), .o_Tick(tick_a), .o_Carry(carry_a), .o_Sat(sat_a), .o_State(state_a));

    bcd_count_ctrl #(.P_DIV(8'd2), .P_LIMIT_T(4'd2), .P_LIMIT_U(4'd5)) dut_b (
        .i_Clk(clk), .i_GRst(rst), .i_Start(start), .i_Stop(stop), .i_Clear(clear), .i_Step(step),
        .o_QU(qu_b), .o_QT(qt_b), .o_Tick(tick_b), .o_Carry(carry_b), .o_Sat(sat_b), .o_State(state_b));

    bcd_count_ctrl #(.P_DIV(8'd2), .P_LIMIT_T(4'd0), .P_LIMIT_U(4'd0)) dut_c (
        .i_Clk(clk), .i_GRst(rst), .i_Start(start), .i_Stop(stop), .i_Clear(clear), .i_Step(step),
        .o_QU(qu_c), .o_QT(qt_c), .o_Tick(tick_c), .o_Carry(carry_c), .o_Sat(sat_c), .o_State(state_c));

    // Reference model: the count is a plain integer 0..99, states are 0 idle, 1 run, 2 pause, 3 sat.
    typedef struct {
        int st;
        int pre;
        int val;
        bit tick;
        bit carry;
    } mstate_t;

    mstate_t m_a, m_b, m_c;

    function automatic mstate_t mreset();
        mstate_t s;
        s.st = 0; s.pre = 0; s.val = 0; s.tick = 0; s.carry = 0;
        return s;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input int div, input int lim,
                                           input logic clr, input logic stp, input logic sta, input int stp_in);
        mstate_t n;
        int se, nv;
        n = s;
        n.tick = 0;
        n.carry = 0;
        se = (stp_in == 0) ? 1 : ((stp_in > 9) ? 9 : stp_in);
        if (clr) begin
            n.st = 0; n.pre = 0; n.val = 0;
        end else if (s.st == 0) begin
            if (sta && !stp) begin n.st = 1; n.pre = 0; end
        end else if (s.st == 1) begin
            if (stp) n.st = 2;
            else if (s.pre == div - 1) begin
                n.pre = 0;
                n.tick = 1;
                n.carry = ((s.val % 10) + se) >= 10;
                nv = s.val + se;
                if (nv >= lim) begin n.val = lim; n.st = 3; end
                else n.val = nv;
            end else n.pre = s.pre + 1;
        end else if (s.st == 2) begin
            if (sta && !stp) n.st = 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= mreset();
            m_b <= mreset();
            m_c <= mreset();
        end else begin
            m_a <= model_next(m_a, 4, 99, clear, stop, start, int'(step));
            m_b <= model_next(m_b, 2, 25, clear, stop, start, int'(step));
            m_c <= model_next(m_c, 2, 0, clear, stop, start, int'(step));
        end
    end

    function automatic logic [12:0] exp_vec(input mstate_t s);
        return {4'(s.val / 10), 4'(s.val % 10), s.tick, s.carry, (s.st == 3), 2'(s.st)};
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/a"}, {qt_a, qu_a, tick_a, carry_a, sat_a, state_a}, exp_vec(m_a));
        chk({tag, "/b"}, {qt_b, qu_b, tick_b, carry_b, sat_b, state_b}, exp_vec(m_b));
        chk({tag, "/c"}, {qt_c, qu_c, tick_c, carry_c, sat_c, state_c}, exp_vec(m_c));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc("clear");
        clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc("start");
        start = 1'b0;
    endtask

    task automatic wait_tick(input int which, input int max_cyc, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < max_cyc; i++) begin
            cyc(tag);
            if ((which == 0 && tick_a) || (which == 1 && tick_b)) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no tick within %0d cycles", tag, max_cyc);
        end
    endtask

    // Directed table for dut_a (P_DIV=4, step 3): outputs expected after each edge.
    typedef struct {
        logic       start;
        logic [3:0] step;
        logic [3:0] exp_qt;
        logic [3:0] exp_qu;
        logic       exp_tick;
        logic       exp_carry;
        logic [1:0] exp_state;
    } vec_t;

    function automatic vec_t mkv(input int sta, input int qt, input int qu, input int tk, input int cy, input int st);
        vec_t v;
        v.start     = (sta != 0);
        v.step      = 4'd3;
        v.exp_qt    = 4'(qt);
        v.exp_qu    = 4'(qu);
        v.exp_tick  = (tk != 0);
        v.exp_carry = (cy != 0);
        v.exp_state = 2'(st);
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mkv(1, 0, 0, 0, 0, 1);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 1);
        tbl[2]  = mkv(0, 0, 0, 0, 0, 1);
        tbl[3]  = mkv(0, 0, 0, 0, 0, 1);
        tbl[4]  = mkv(0, 0, 3, 1, 0, 1);
        tbl[5]  = mkv(0, 0, 3, 0, 0, 1);
        tbl[6]  = mkv(0, 0, 3, 0, 0, 1);
        tbl[7]  = mkv(0, 0, 3, 0, 0, 1);
        tbl[8]  = mkv(0, 0, 6, 1, 0, 1);
        tbl[9]  = mkv(0, 0, 6, 0, 0, 1);
        tbl[10] = mkv(0, 0, 6, 0, 0, 1);
        tbl[11] = mkv(0, 0, 6, 0, 0, 1);
        tbl[12] = mkv(0, 0, 9, 1, 0, 1);
        tbl[13] = mkv(0, 0, 9, 0, 0, 1);
        tbl[14] = mkv(0, 0, 9, 0, 0, 1);
        tbl[15] = mkv(0, 0, 9, 0, 0, 1);
        tbl[16] = mkv(0, 1, 2, 1, 1, 1);
        tbl[17] = mkv(0, 1, 2, 0, 0, 1);

        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; step = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_a_zero", 13'({qt_a, qu_a, tick_a, carry_a, sat_a, state_a}), 13'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            start = tbl[i].start;
            step  = tbl[i].step;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), 13'({qt_a, qu_a, tick_a, carry_a, state_a}),
                13'({tbl[i].exp_qt, tbl[i].exp_qu, tbl[i].exp_tick, tbl[i].exp_carry, tbl[i].exp_state}));
            check_all("vec");
        end
        start = 1'b0;

        // Stop lands on the terminal prescaler cycle, then resume seven cycles later.
        pulse_clear();
        chk("clr_state", 13'(state_a), 13'd0);
        step = 4'd1;
        pulse_start();
        repeat (3) cyc("pre_run");
        stop = 1'b1;
        cyc("stop_term");
        stop = 1'b0;
        chk("stop_term_state", 13'(state_a), 13'd2);
        chk("stop_term_tick", 13'({tick_a, qt_a, qu_a}), 13'd0);
        repeat (7) cyc("paused");
        chk("paused_val", 13'({state_a, qt_a, qu_a}), 13'({2'd2, 8'h00}));
        pulse_start();
        chk("resume_state", 13'({state_a, qu_a}), 13'({2'd1, 4'd0}));
        cyc("resume_upd");
        chk("resume_upd", 13'({tick_a, qt_a, qu_a}), 13'({1'b1, 8'h01}));

        // Clear on the terminal prescaler cycle.
        pulse_clear();
        step = 4'd5;
        pulse_start();
        wait_tick(0, 8, "wt_05");
        chk("val_05", 13'({qt_a, qu_a}), 13'(bcd(5)));
        repeat (3) cyc("pre_term");
        clear = 1'b1;
        cyc("clear_term");
        clear = 1'b0;
        chk("clear_term", 13'({qt_a, qu_a, tick_a, carry_a, state_a}), 13'd0);

        // Limit 25 with step 7 on dut_b; dut_c (limit 0) saturates on its first update.
        step = 4'd7;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_tick(1, 6, "wt_b");
            chk($sformatf("lim25_%0d", k), 13'({qt_b, qu_b}), 13'(bcd((k == 3) ? 25 : 7 * (k + 1))));
            if (k == 0) chk("lim0_sat", 13'({qt_c, qu_c, sat_c, state_c}), 13'({8'h00, 1'b1, 2'd3}));
        end
        chk("lim25_sat", 13'({sat_b, state_b}), 13'({1'b1, 2'd3}));
        pulse_start();
        repeat (3) cyc("sat_hold");
        chk("sat_hold", 13'({qt_b, qu_b, state_b}), 13'({bcd(25), 2'd3}));
        pulse_clear();
        chk("sat_clear", 13'({qt_b, qu_b, state_b}), 13'd0);

        // Step clamping and saturation at 99 on dut_a.
        step = 4'd0;
        pulse_start();
        wait_tick(0, 8, "wt_s0");
        chk("step0", 13'({qt_a, qu_a}), 13'(bcd(1)));
        step = 4'hF;
        wait_tick(0, 8, "wt_sf");
        chk("stepF", 13'({qt_a, qu_a, carry_a}), 13'({bcd(10), 1'b1}));
        step = 4'd9;
        for (int k = 1; k <= 9; k++) begin
            wait_tick(0, 8, "wt_s9");
            chk($sformatf("step9_%0d", k), 13'({qt_a, qu_a}), 13'(bcd(10 + 9 * k)));
        end
        step = 4'd4;
        wait_tick(0, 8, "wt_95");
        chk("val_95", 13'({qt_a, qu_a}), 13'(bcd(95)));
        step = 4'd9;
        wait_tick(0, 8, "wt_99");
        chk("sat_99", 13'({qt_a, qu_a, carry_a, sat_a, state_a}), 13'({bcd(99), 1'b1, 1'b1, 2'd3}));

        // Asynchronous reset while running at 05.
        pulse_clear();
        step = 4'd5;
        pulse_start();
        wait_tick(0, 8, "wt_r05");
        chk("pre_rst_05", 13'({qt_a, qu_a}), 13'(bcd(5)));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", 13'({qt_a, qu_a, tick_a, carry_a, sat_a, state_a}), 13'd0);
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_rst");
        chk("post_rst_idle", 13'({state_a, qu_a}), 13'd0);

        // Random commands and steps, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            clear = ($urandom_range(0, 31) == 0);
            stop  = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 3) == 0);
            step  = 4'($urandom_range(0, 15));
            cyc("rand");
        end
        rst = 1'b0; clear = 1'b0; stop = 1'b0; start = 1'b0;
        cyc("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
